// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//
// Two-stage pipelined ALU with valid/ready flow control. It replaces the
// 4-bit single-cycle alu with a parametrised datapath, signed flags and an
// internal accumulator that can stand in for the A operand.
//
// Stage 1 captures an operation on handshake (in_valid && in_ready).
// Stage 2 evaluates the captured operation and registers RESULT and the
// flags when stage 1 advances into it. The accumulator is written with
// every result that moves from stage 1 to stage 2.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   in_valid        : an operation is presented on OPCODE/MODE/OP1/OP2
//   in_ready        : stage 1 can take an operation this cycle
//   OPCODE          : 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                     101 NOT A, 110 SHL, 111 SHR (logical)
//   MODE            : 0 -> A is OP1, 1 -> A is the accumulator
//   OP1, OP2        : A operand, B operand / shift amount
//   acc_clr         : clears the accumulator at the next edge
//   out_valid       : RESULT and flags hold a result
//   out_ready       : the consumer takes the result this cycle
//   RESULT          : registered result
//   CARRY/ZERO/NEG/OVF : registered flags for RESULT
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       OPCODE,
  input  logic             MODE,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             ZERO,
  output logic             NEG,
  output logic             OVF
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } opcode_e;

  // Stage 1 holding register
  logic             s1_valid_q, s1_valid_d;
  opcode_e          s1_op_q, s1_op_d;
  logic             s1_mode_q, s1_mode_d;
  logic [WIDTH-1:0] s1_op1_q, s1_op1_d;
  logic [WIDTH-1:0] s1_op2_q, s1_op2_d;

  // Stage 2 output register
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  // Accumulator
  logic [WIDTH-1:0] acc_q, acc_d;

  // Handshake terms
  logic             s2_adv;
  logic             s1_adv;
  logic             accept;

  // Datapath intermediates
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [SHW-1:0]   shAmt;
  logic             shOver;
  logic [WIDTH:0]   sumAdd;
  logic [WIDTH:0]   sumSub;
  logic [WIDTH:0]   shlWide;
  logic [WIDTH:0]   shrWide;
  logic [WIDTH-1:0] aluRes;
  logic             aluCarry;
  logic             aluOvf;

  // Elastic pipeline handshake. Stage 2 can take new data when it is empty
  // or its contents leave this cycle; stage 1 can take new data when it is
  // empty or it moves into stage 2 this cycle. While rst is high s1_valid_q
  // is forced to 0, so in_ready reads 1.
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  // Stage 2 evaluation from the stage 1 contents. The A operand reads the
  // accumulator at the same edge that will overwrite it, so back-to-back
  // accumulator ops chain without a hazard.
  // Shifts run on a WIDTH+1 wide word so the bit shifted out lands in the
  // extra bit: the top bit for SHL, bit 0 for SHR. An amount of exactly WIDTH
  // still yields the last bit shifted out; anything above WIDTH, compared on
  // the full OP2 value, gives a zero result and zero carry.
  always_comb begin
    opA      = s1_mode_q ? acc_q : s1_op1_q;
    opB      = s1_op2_q;
    shAmt    = opB[SHW-1:0];
    shOver   = (opB > WIDTH'(WIDTH));
    sumAdd   = {1'b0, opA} + {1'b0, opB};
    sumSub   = {1'b0, opA} + {1'b0, ~opB} + {{WIDTH{1'b0}}, 1'b1};
    shlWide  = {1'b0, opA} << shAmt;
    shrWide  = {opA, 1'b0} >> shAmt;
    aluRes   = '0;
    aluCarry = 1'b0;
    aluOvf   = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        aluRes   = sumAdd[WIDTH-1:0];
        aluCarry = sumAdd[WIDTH];
        aluOvf   = (opA[WIDTH-1] == opB[WIDTH-1]) &&
                   (sumAdd[WIDTH-1] != opA[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes   = sumSub[WIDTH-1:0];
        aluCarry = sumSub[WIDTH];
        aluOvf   = (opA[WIDTH-1] != opB[WIDTH-1]) &&
                   (sumSub[WIDTH-1] != opA[WIDTH-1]);
      end
      OP_AND: aluRes = opA & opB;
      OP_OR:  aluRes = opA | opB;
      OP_XOR: aluRes = opA ^ opB;
      OP_NOT: aluRes = ~opA;
      OP_SHL: begin
        if (!shOver) begin
          aluRes   = shlWide[WIDTH-1:0];
          aluCarry = shlWide[WIDTH];
        end
      end
      OP_SHR: begin
        if (!shOver) begin
          aluRes   = shrWide[WIDTH:1];
          aluCarry = shrWide[0];
        end
      end
      default: begin
        aluRes   = '0;
        aluCarry = 1'b0;
        aluOvf   = 1'b0;
      end
    endcase
  end

  // Next-state for both stages and the accumulator. Every register holds by
  // default. Stage 1 reloads on accept, otherwise empties when it advances.
  // Stage 2 only loads when stage 1 advances, which keeps RESULT and flags
  // stable during backpressure. acc_clr wins over the accumulator load.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_mode_d   = s1_mode_q;
    s1_op1_d    = s1_op1_q;
    s1_op2_d    = s1_op2_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = opcode_e'(OPCODE);
      s1_mode_d  = MODE;
      s1_op1_d   = OP1;
      s1_op2_d   = OP2;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
    end

    if (s1_adv) begin
      result_d = aluRes;
      carry_d  = aluCarry;
      zero_d   = (aluRes == '0);
      neg_d    = aluRes[WIDTH-1];
      ovf_d    = aluOvf;
    end

    if (acc_clr) begin
      acc_d = '0;
    end else if (s1_adv) begin
      acc_d = aluRes;
    end
  end

  // State registers. Reset empties both stages and zeroes the visible
  // outputs and the accumulator immediately, dropping any in-flight ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_mode_q   <= 1'b0;
      s1_op1_q    <= '0;
      s1_op2_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_mode_q   <= s1_mode_d;
      s1_op1_q    <= s1_op1_d;
      s1_op2_q    <= s1_op2_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign RESULT    = result_q;
  assign CARRY     = carry_q;
  assign ZERO      = zero_q;
  assign NEG       = neg_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
//
// Directed testbench for alu_pipe at WIDTH=8. Inputs change 1-2 time units
// after a rising edge and outputs are sampled there, away from the edge.
// Flags are compared as the packed word {CARRY, ZERO, NEG, OVF}.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int WIDTH = 8;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] ANDOP = 3'b010;
  localparam logic [2:0] OROP = 3'b011;
  localparam logic [2:0] XOROP = 3'b100;
  localparam logic [2:0] NOTOP = 3'b101;
  localparam logic [2:0] SHL = 3'b110;
  localparam logic [2:0] SHR = 3'b111;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       OPCODE;
  logic             MODE;
  logic [WIDTH-1:0] OP1;
  logic [WIDTH-1:0] OP2;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] RESULT;
  logic             CARRY;
  logic             ZERO;
  logic             NEG;
  logic             OVF;

  int checkCount = 0;
  int passCount  = 0;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .OPCODE    (OPCODE),
    .MODE      (MODE),
    .OP1       (OP1),
    .OP2       (OP2),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .RESULT    (RESULT),
    .CARRY     (CARRY),
    .ZERO      (ZERO),
    .NEG       (NEG),
    .OVF       (OVF)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the request side and let combinational outputs settle
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic m,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic clr);
    in_valid = v;
    OPCODE   = op;
    MODE     = m;
    OP1      = a;
    OP2      = b;
    acc_clr  = clr;
    #1;
  endtask

  // One isolated op with out_ready high: accept, one-cycle latency, result
  task automatic runSingle(input string tag, input logic [2:0] op, input logic m,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] expRes, input logic [3:0] expFlags);
    applyStimulus(1'b1, op, m, a, b, 1'b0);
    tick();
    applyStimulus(1'b0, op, m, a, b, 1'b0);
    checkOutput({tag, " not yet valid"}, out_valid, 1'b0);
    tick();
    checkOutput({tag, " valid"}, out_valid, 1'b1);
    checkOutput({tag, " result"}, RESULT, expRes);
    checkOutput({tag, " flags"}, {CARRY, ZERO, NEG, OVF}, expFlags);
    tick();
    checkOutput({tag, " drained"}, out_valid, 1'b0);
  endtask

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    rst       = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, ADD, 1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    #2;
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset result", RESULT, 8'h00);
    checkOutput("reset flags", {CARRY, ZERO, NEG, OVF}, 4'b0000);
    checkOutput("reset in_ready", in_ready, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Arithmetic, logic and shift vectors
    runSingle("add wrap",     ADD,   1'b0, 8'hFF, 8'h01, 8'h00, 4'b1100);
    runSingle("add ovf",      ADD,   1'b0, 8'h7F, 8'h01, 8'h80, 4'b0011);
    runSingle("sub ovf",      SUB,   1'b0, 8'h80, 8'h01, 8'h7F, 4'b1001);
    runSingle("sub borrow",   SUB,   1'b0, 8'h01, 8'h02, 8'hFF, 4'b0010);
    runSingle("and",          ANDOP, 1'b0, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    runSingle("or",           OROP,  1'b0, 8'hF0, 8'h0F, 8'hFF, 4'b0010);
    runSingle("xor",          XOROP, 1'b0, 8'hAA, 8'hAA, 8'h00, 4'b0100);
    runSingle("not",          NOTOP, 1'b0, 8'h0F, 8'h55, 8'hF0, 4'b0010);
    runSingle("shl by 1",     SHL,   1'b0, 8'h81, 8'h01, 8'h02, 4'b1000);
    runSingle("shl by 0",     SHL,   1'b0, 8'h81, 8'h00, 8'h81, 4'b0010);
    runSingle("shr by 1",     SHR,   1'b0, 8'h81, 8'h01, 8'h40, 4'b1000);
    runSingle("shr by 8",     SHR,   1'b0, 8'h81, 8'h08, 8'h00, 4'b1100);
    runSingle("shr by 9",     SHR,   1'b0, 8'h81, 8'h09, 8'h00, 4'b0100);

    // Backpressure: two ops buffered, the third is refused
    out_ready = 1'b0;
    applyStimulus(1'b1, ADD, 1'b0, 8'h01, 8'h01, 1'b0);
    checkOutput("bp ready A", in_ready, 1'b1);
    tick();
    applyStimulus(1'b1, ADD, 1'b0, 8'h02, 8'h02, 1'b0);
    checkOutput("bp ready B", in_ready, 1'b1);
    tick();
    applyStimulus(1'b1, ADD, 1'b0, 8'h03, 8'h03, 1'b0);
    checkOutput("bp full ready", in_ready, 1'b0);
    checkOutput("bp head valid", out_valid, 1'b1);
    checkOutput("bp head result", RESULT, 8'h02);
    tick();
    checkOutput("bp hold ready", in_ready, 1'b0);
    checkOutput("bp hold result", RESULT, 8'h02);
    tick();
    checkOutput("bp hold2 result", RESULT, 8'h02);
    checkOutput("bp hold2 valid", out_valid, 1'b1);
    out_ready = 1'b1;
    #1;
    checkOutput("bp release ready", in_ready, 1'b1);
    tick();
    applyStimulus(1'b0, ADD, 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("bp second valid", out_valid, 1'b1);
    checkOutput("bp second result", RESULT, 8'h04);
    tick();
    checkOutput("bp third valid", out_valid, 1'b1);
    checkOutput("bp third result", RESULT, 8'h06);
    tick();
    checkOutput("bp no duplicate", out_valid, 1'b0);
    tick();
    checkOutput("bp stays empty", out_valid, 1'b0);

    // Accumulator chain, with acc_clr on the third op's transfer
    applyStimulus(1'b0, ADD, 1'b1, 8'h00, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b1, ADD, 1'b1, 8'hEE, 8'h05, 1'b0);
    tick();
    applyStimulus(1'b1, ADD, 1'b1, 8'hEE, 8'h05, 1'b0);
    tick();
    checkOutput("chain 1 valid", out_valid, 1'b1);
    checkOutput("chain 1 result", RESULT, 8'h05);
    applyStimulus(1'b1, ADD, 1'b1, 8'hEE, 8'h05, 1'b0);
    tick();
    checkOutput("chain 2 result", RESULT, 8'h0A);
    applyStimulus(1'b0, ADD, 1'b1, 8'hEE, 8'h05, 1'b1);
    tick();
    checkOutput("chain 3 valid", out_valid, 1'b1);
    checkOutput("chain 3 result", RESULT, 8'h0F);
    checkOutput("chain 3 flags", {CARRY, ZERO, NEG, OVF}, 4'b0000);
    applyStimulus(1'b0, ADD, 1'b1, 8'h00, 8'h00, 1'b0);
    runSingle("chain after clr", ADD, 1'b1, 8'hEE, 8'h01, 8'h01, 4'b0000);

    // Reset with both stages full
    out_ready = 1'b0;
    applyStimulus(1'b1, ADD, 1'b0, 8'h10, 8'h20, 1'b0);
    tick();
    applyStimulus(1'b1, ADD, 1'b0, 8'h01, 8'h01, 1'b0);
    tick();
    applyStimulus(1'b0, ADD, 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("prerst valid", out_valid, 1'b1);
    checkOutput("prerst result", RESULT, 8'h30);
    rst = 1'b1;
    #1;
    checkOutput("midrst valid", out_valid, 1'b0);
    checkOutput("midrst result", RESULT, 8'h00);
    checkOutput("midrst flags", {CARRY, ZERO, NEG, OVF}, 4'b0000);
    checkOutput("midrst in_ready", in_ready, 1'b1);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("postrst no stale", out_valid, 1'b0);
    end
    runSingle("acc after reset", ADD, 1'b1, 8'hEE, 8'h03, 8'h03, 4'b0000);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined ALU that succeeds the 4-bit single-cycle `alu`. It generalises operand width and adds signed flags, an internal accumulator operand mode, and valid/ready flow control with full backpressure. It sits between the instruction issue logic and the writeback path, and is the unit the formal and simulation benches target for datapath checks.

## Interface
- `WIDTH`, 8, operand/result width in bits; legal values ≥ 2.
- `SHW`, `$clog2(WIDTH)+1`, number of OP2 LSBs used as the shift amount. Derived; not overridden.

- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: an operation is presented.
- `in_ready` out 1: the stage-1 register can accept an operation.
- `OPCODE` in 3: operation select.
- `MODE` in 1: 0 = A operand is OP1; 1 = A operand is the accumulator.
- `OP1` in WIDTH: A operand.
- `OP2` in WIDTH: B operand, or shift amount.
- `acc_clr` in 1: synchronous accumulator clear.
- `out_valid` out 1: RESULT and flags are valid.
- `out_ready` in 1: the consumer accepts the result.
- `RESULT` out WIDTH: registered result.
- `CARRY`, `ZERO`, `NEG`, `OVF` out 1 each: registered flags.

## Operation
- Opcodes, with A = OP1 or the accumulator and B = OP2:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT A.
  - 110 SHL: A<<B.
  - 111 SHR: logical A>>B.
- All arithmetic is modulo 2^WIDTH.
- CARRY:
  - ADD: carry out.
  - SUB: carry of A+~B+1, so 1 means no borrow (A ≥ B unsigned).
  - Shifts: the last bit shifted out when the amount is 1..WIDTH; 0 when the amount is 0 or greater than WIDTH.
  - Logic ops: 0.
- Shift amount is OP2 taken as unsigned. An amount of WIDTH or more gives RESULT 0.
- OVF is two's-complement signed overflow for ADD and SUB; 0 for all other opcodes.
- ZERO = (RESULT == 0). NEG = RESULT[WIDTH-1].
- Stage 1 (S1) registers OPCODE, MODE, OP1 and OP2 on accept, i.e. when `in_valid && in_ready`.
- Stage 2 (S2) computes from the S1 contents and registers RESULT and the flags when S1 advances into it.
- The accumulator (WIDTH bits) is loaded with RESULT on every S1→S2 transfer, regardless of MODE.
  - The A operand is read from the accumulator at that same transfer, so back-to-back MODE=1 ops chain without a hazard.
- `acc_clr` sets the accumulator to 0 at the next edge and takes priority over the load.
  - An op transferring in the same cycle uses the old accumulator value.
  - That op's RESULT is still output normally.
- Flow control is an elastic pipeline:
  - `s2_adv = !out_valid || out_ready`.
  - `s1_adv = s1_valid && s2_adv`.
  - `in_ready = !s1_valid || s2_adv` (combinational).
- While `out_valid && !out_ready`, RESULT and all flags hold stable.
- Results are delivered in order, with no loss and no duplication.

## Timing
- Reset, asynchronous and effective immediately:
  - `s1_valid = 0`, `out_valid = 0`.
  - RESULT, CARRY, ZERO, NEG, OVF = 0.
  - Accumulator = 0.
  - `in_ready` reads 1 while `rst` is high.
- Latency: an op accepted at edge N appears with `out_valid = 1` after edge N+1, provided S2 is free.
- Throughput: 1 op/cycle while `out_ready = 1`.
- With `out_ready` held at 0, at most 2 ops are buffered (S1 and S2); `in_ready` then drops to 0.
- Simultaneous events:
  - Consume and refill in one cycle is allowed with no bubble: S2 accepts S1 in the same edge that the consumer takes RESULT.
  - Accept and S1 advance in one cycle is allowed.
- Reset asserted mid-operation discards all in-flight ops. No result is emitted for them after reset is released.
- `in_valid` may drop without being accepted. Operand inputs are sampled only on accept.

## Test plan
- **ADD wrap, WIDTH=8:** ADD with OP1=0xFF, OP2=0x01.
  - RESULT 0x00, CARRY 1, ZERO 1, NEG 0, OVF 0.
  - `out_valid` high 2 edges after accept.
- **SUB signed overflow:** SUB with OP1=0x80, OP2=0x01.
  - RESULT 0x7F, CARRY 1, OVF 1, NEG 0.
- **SUB borrow:** SUB with OP1=0x01, OP2=0x02.
  - RESULT 0xFF, CARRY 0, NEG 1, OVF 0.
- **Accumulator chain:** pulse `acc_clr`, then issue three back-to-back MODE=1 ADDs with OP2=5.
  - Results 0x05, 0x0A, 0x0F on consecutive cycles.
  - `acc_clr` asserted with the 3rd op: that result is still 0x0F, and a following MODE=1 ADD with OP2=1 gives 0x01.
- **Backpressure:** hold `out_ready = 0` and present 3 ops.
  - Exactly 2 are accepted, `in_ready` is 0, RESULT is stable.
  - Raise `out_ready`: all 3 results emerge in order, one per cycle, none duplicated.
- **Shifts and reset:**
  - SHL 0x81 by 1 → 0x02, CARRY 1.
  - SHR 0x81 by 8 → 0x00, CARRY 1.
  - SHR 0x81 by 9 → 0x00, CARRY 0.
  - Assert `rst` with both stages full: `out_valid` and RESULT go to 0 without waiting for an edge, the accumulator is 0, and no stale output appears after release.
